// File: rtl/down_counter_borrow.sv
// down_counter_borrow: loadable modulo-2^WIDTH down counter with a registered borrow pulse.
// Build option ONESHOT_EN: stop at zero (DONE state) instead of wrapping.
module down_counter_borrow #(
   parameter int WIDTH = 4
) (
   input  logic             input_CLK,
   input  logic             input_RST,
   input  logic             input_LOAD,
   input  logic [WIDTH-1:0] input_D,
   input  logic             input_ENA,
   output logic [WIDTH-1:0] output_Y,
   output logic             borrow,
   output logic             output_ZERO,
   output logic             output_BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             borrow_q, borrow_d;
   logic             busy_q;

   always_ff @(posedge input_CLK) begin
      if (input_RST) begin
         state_q  <= IDLE;
         y_q      <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         borrow_q <= borrow_d;
         busy_q   <= (state_d == RUN);
      end
   end

   // LOAD overrides counting in every state; IDLE and DONE otherwise just hold.
   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      borrow_d = 1'b0;
      if (input_LOAD) begin
         y_d = input_D;
`ifdef ONESHOT_EN
         state_d = (input_D == '0) ? DONE : RUN;
`else
         state_d = RUN;
`endif
      end else if (state_q == RUN && input_ENA) begin
`ifdef ONESHOT_EN
         // Never wraps: the step that reaches zero also parks the FSM in DONE.
         if (y_q != '0) begin
            y_d = y_q - ONE;
         end
         if (y_q <= ONE) begin
            state_d = DONE;
         end
`else
         y_d      = y_q - ONE;
         borrow_d = (y_q == '0);
`endif
      end
   end

   assign output_Y    = y_q;
   assign borrow      = borrow_q;
   assign output_BUSY = busy_q;
   assign output_ZERO = (y_q == '0);

endmodule
